// File: rtl/gpio_bus_arbiter_pkg.sv
// Shared GPIO register map, arbiter FSM states and the access legality check.
package gpio_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Read-to-clear status registers; the only readable locations.
  localparam logic [31:0] GPIO_KEY_OFS = 32'h0000_0000;
  localparam logic [31:0] GPIO_SW_OFS  = 32'h0000_0004;
  localparam logic [31:0] GPIO_WR_LO   = 32'h0000_0008;
  localparam logic [31:0] GPIO_WR_HI   = 32'h0000_002C;

  function automatic logic addr_legal(input logic wr, input logic [31:0] addr);
    if (addr[1:0] != 2'b00) begin
      return 1'b0;
    end
    if (wr) begin
      return (addr >= GPIO_WR_LO) && (addr <= GPIO_WR_HI);
    end
    return (addr == GPIO_KEY_OFS) || (addr == GPIO_SW_OFS);
  endfunction

endpackage

// File: rtl/gpio_bus_arbiter_rr_arbiter.sv
// Combinational round-robin select: first requester at or after the pointer wins.
module rr_arbiter
  import gpio_bus_arbiter_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr_i) + i) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Round-robin sharing of the GPIO register port; one strobe cycle per legal access.
module gpio_bus_arbiter
  import gpio_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned AW          = 12,
  parameter int unsigned DW          = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS-1:0]    m_wr,
  input  logic [NUM_MASTERS*AW-1:0] m_addr,
  input  logic [NUM_MASTERS*DW-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic [NUM_MASTERS-1:0]    m_err,
  output logic [DW-1:0]             m_rdata,
  output logic                      gpio_cs_n,
  output logic                      gpio_rd_n,
  output logic                      gpio_wr_n,
  output logic [AW-1:0]             gpio_addr,
  output logic [DW-1:0]             gpio_wdata,
  input  logic [DW-1:0]             gpio_rdata,
  output logic                      busy
);

  localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  state_e                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic                   cs_n_q, cs_n_d;
  logic                   rd_n_q, rd_n_d;
  logic                   wr_n_q, wr_n_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [DW-1:0]          wdata_q, wdata_d;
  logic [NUM_MASTERS-1:0] ack_q, ack_d;
  logic [NUM_MASTERS-1:0] err_q, err_d;
  logic [DW-1:0]          rdata_q, rdata_d;
  logic                   busy_q, busy_d;

  logic [AW-1:0]          addr_arr  [NUM_MASTERS];
  logic [DW-1:0]          wdata_arr [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [IW-1:0]          arb_idx;
  logic                   arb_valid;
  logic                   sel_wr;
  logic                   sel_legal;

  always_comb begin
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      addr_arr[k]  = m_addr[k*AW +: AW];
      wdata_arr[k] = m_wdata[k*DW +: DW];
    end
  end

  rr_arbiter #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_rr (
    .req_i   (m_req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign sel_wr    = m_wr[arb_idx];
  assign sel_legal = addr_legal(sel_wr, 32'(addr_arr[arb_idx]));

  // Strobes, ack and err default inactive so each is a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cs_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    wr_n_d  = 1'b1;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gidx_d = arb_idx;
          ptr_d  = (arb_idx == IW'(NUM_MASTERS - 1)) ? '0 : arb_idx + 1'b1;
          if (sel_legal) begin
            state_d = ST_ACCESS;
            cs_n_d  = 1'b0;
            rd_n_d  = sel_wr;
            wr_n_d  = ~sel_wr;
            addr_d  = addr_arr[arb_idx];
            wdata_d = wdata_arr[arb_idx];
          end else begin
            state_d = ST_RESP;
            ack_d   = arb_gnt;
            err_d   = arb_gnt;
            rdata_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        state_d        = ST_RESP;
        ack_d[gidx_q]  = 1'b1;
        rdata_d        = gpio_rdata;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign m_ack      = ack_q;
  assign m_err      = err_q;
  assign m_rdata    = rdata_q;
  assign gpio_cs_n  = cs_n_q;
  assign gpio_rd_n  = rd_n_q;
  assign gpio_wr_n  = wr_n_q;
  assign gpio_addr  = addr_q;
  assign gpio_wdata = wdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Scoreboard bench: stimulus pushes expected strobes/acks, a negedge monitor pops and compares.
module tb_gpio_bus_arbiter;

  localparam int NM = 2;
  localparam int AW = 12;
  localparam int DW = 32;

  logic             clk;
  logic             reset;
  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_wr;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_ack;
  logic [NM-1:0]    m_err;
  logic [DW-1:0]    m_rdata;
  logic             gpio_cs_n;
  logic             gpio_rd_n;
  logic             gpio_wr_n;
  logic [AW-1:0]    gpio_addr;
  logic [DW-1:0]    gpio_wdata;
  logic [DW-1:0]    gpio_rdata;
  logic             busy;

  gpio_bus_arbiter #(
    .NUM_MASTERS (NM),
    .AW          (AW),
    .DW          (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m_req      (m_req),
    .m_wr       (m_wr),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_ack      (m_ack),
    .m_err      (m_err),
    .m_rdata    (m_rdata),
    .gpio_cs_n  (gpio_cs_n),
    .gpio_rd_n  (gpio_rd_n),
    .gpio_wr_n  (gpio_wr_n),
    .gpio_addr  (gpio_addr),
    .gpio_wdata (gpio_wdata),
    .gpio_rdata (gpio_rdata),
    .busy       (busy)
  );

  typedef struct {
    int          m;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } ack_t;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } strb_t;

  typedef struct {
    int          k;
    bit          wr;
    logic [11:0] a;
    logic [31:0] d;
    bit          legal;
  } vec_t;

  ack_t  sb_ack[$];
  strb_t sb_strb[$];
  ack_t  ea;
  strb_t es;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int ok_ack_cnt = 0;
  int req_seq = 0;
  int done_seq = 0;
  int req_kind = 0;
  logic [AW-1:0] exp_hold = '0;
  int rem[NM];
  vec_t vt[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: the only process that compares and steps the counters.
  always @(negedge clk) begin
    logic [NM-1:0] one;
    if (!reset) begin
      cmp("stray_strobe", 64'(gpio_cs_n & ~(gpio_rd_n & gpio_wr_n)), 64'd0);
      if (!gpio_cs_n) begin
        strobe_cnt++;
        if (sb_strb.size() == 0) begin
          cmp("unexpected_strobe", 64'd1, 64'd0);
        end else begin
          es = sb_strb.pop_front();
          cmp("strobe_rd_n", 64'(gpio_rd_n), 64'(es.wr));
          cmp("strobe_wr_n", 64'(gpio_wr_n), 64'(!es.wr));
          cmp("strobe_addr", 64'(gpio_addr), 64'(es.addr));
          if (es.wr) cmp("strobe_wdata", 64'(gpio_wdata), 64'(es.wdata));
          cmp("strobe_cycle", 64'(cyc), 64'(es.cyc));
        end
      end
      if (m_ack != '0) begin
        if (sb_ack.size() == 0) begin
          cmp("unexpected_ack", 64'(m_ack), 64'd0);
        end else begin
          ea = sb_ack.pop_front();
          one = '0;
          one[ea.m] = 1'b1;
          if (!ea.err) ok_ack_cnt++;
          cmp("ack_vec", 64'(m_ack), 64'(one));
          cmp("err_vec", 64'(m_err), ea.err ? 64'(one) : 64'd0);
          cmp("ack_rdata", 64'(m_rdata), 64'(ea.rdata));
          cmp("ack_cycle", 64'(cyc), 64'(ea.cyc));
          cmp("ack_busy", 64'(busy), 64'd1);
        end
      end
    end
    if (req_seq != done_seq) begin
      done_seq = req_seq;
      case (req_kind)
        1: begin
          cmp("rst_strobes", 64'({gpio_cs_n, gpio_rd_n, gpio_wr_n}), 64'd7);
          cmp("rst_addr", 64'(gpio_addr), 64'd0);
          cmp("rst_wdata", 64'(gpio_wdata), 64'd0);
          cmp("rst_ack_err", 64'({m_ack, m_err}), 64'd0);
          cmp("rst_rdata", 64'(m_rdata), 64'd0);
          cmp("rst_busy", 64'(busy), 64'd0);
        end
        2: begin
          cmp("drain_ack_q", 64'(sb_ack.size()), 64'd0);
          cmp("drain_strb_q", 64'(sb_strb.size()), 64'd0);
          cmp("drain_busy", 64'(busy), 64'd0);
          cmp("strobes_eq_ok_acks", 64'(strobe_cnt), 64'(ok_ack_cnt));
        end
        3: cmp("addr_hold", 64'(gpio_addr), 64'(exp_hold));
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < NM; k++) begin
      if (m_ack[k] && rem[k] > 0) begin
        rem[k]--;
        if (rem[k] == 0) m_req[k] = 1'b0;
      end
    end
  endtask

  task automatic request(input int kind);
    req_kind = kind;
    req_seq++;
  endtask

  task automatic start(input int k, input bit wr, input logic [11:0] a,
                       input logic [31:0] d, input int n);
    m_wr[k]            = wr;
    m_addr[k*AW +: AW] = a;
    m_wdata[k*DW +: DW] = d;
    rem[k]             = n;
    m_req[k]           = 1'b1;
  endtask

  task automatic exp_ok(input int k, input bit wr, input logic [11:0] a,
                        input logic [31:0] d, input logic [31:0] rd, input int scyc);
    strb_t s;
    ack_t  r;
    s.wr = wr; s.addr = a; s.wdata = d; s.cyc = scyc;
    r.m = k; r.err = 1'b0; r.rdata = rd; r.cyc = scyc + 1;
    sb_strb.push_back(s);
    sb_ack.push_back(r);
  endtask

  task automatic exp_err(input int k, input int acyc);
    ack_t r;
    r.m = k; r.err = 1'b1; r.rdata = '0; r.cyc = acyc;
    sb_ack.push_back(r);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((sb_ack.size() != 0 || sb_strb.size() != 0) && b < 60) begin
      tick();
      b++;
    end
    tick();
    request(2);
    tick();
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    m_req      = '0;
    m_wr       = '0;
    m_addr     = '0;
    m_wdata    = '0;
    gpio_rdata = '0;
    for (int k = 0; k < NM; k++) rem[k] = 0;

    vt = '{
      '{1, 1'b0, 12'h008, 32'h0,  1'b0},
      '{1, 1'b1, 12'h00A, 32'h33, 1'b0},
      '{0, 1'b1, 12'h030, 32'h44, 1'b0},
      '{0, 1'b0, 12'h00C, 32'h0,  1'b0},
      '{0, 1'b1, 12'h000, 32'h55, 1'b0},
      '{1, 1'b1, 12'h02C, 32'h5A, 1'b1},
      '{0, 1'b1, 12'h008, 32'h11, 1'b1},
      '{1, 1'b0, 12'h004, 32'h0,  1'b1},
      '{0, 1'b0, 12'h001, 32'h0,  1'b0}
    };

    repeat (3) tick();
    reset = 1'b0;
    request(1);
    tick();

    // 1: single read of KEY
    n = cyc;
    gpio_rdata = 32'h0000_0002;
    start(0, 1'b0, 12'h000, 32'h0, 1);
    exp_ok(0, 1'b0, 12'h000, 32'h0, 32'h2, n + 1);
    drain();

    // 2: simultaneous writes after reset, m0 first
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    request(1);
    n = cyc;
    gpio_rdata = 32'h1234_5678;
    start(0, 1'b1, 12'h010, 32'h79, 1);
    start(1, 1'b1, 12'h014, 32'h24, 1);
    exp_ok(0, 1'b1, 12'h010, 32'h79, 32'h1234_5678, n + 1);
    exp_ok(1, 1'b1, 12'h014, 32'h24, 32'h1234_5678, n + 4);
    drain();

    // 3: 12 back-to-back transactions alternate 0,1,...
    n = cyc;
    start(0, 1'b1, 12'h018, 32'hA0, 6);
    start(1, 1'b1, 12'h01C, 32'hB0, 6);
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) exp_ok(0, 1'b1, 12'h018, 32'hA0, 32'h1234_5678, n + 1 + 3 * i);
      else            exp_ok(1, 1'b1, 12'h01C, 32'hB0, 32'h1234_5678, n + 1 + 3 * i);
    end
    drain();

    // 4: legality boundaries, one access at a time
    gpio_rdata = 32'hCAFE_0001;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) begin
        exp_hold = 12'h01C;
        request(3);
        tick();
      end
      n = cyc;
      start(vt[i].k, vt[i].wr, vt[i].a, vt[i].d, 1);
      if (vt[i].legal) exp_ok(vt[i].k, vt[i].wr, vt[i].a, vt[i].d, 32'hCAFE_0001, n + 1);
      else             exp_err(vt[i].k, n + 1);
      drain();
    end

    // 6: held request gives three reads spaced 3 cycles
    n = cyc;
    gpio_rdata = 32'h0000_0005;
    start(0, 1'b0, 12'h004, 32'h0, 3);
    for (int i = 0; i < 3; i++) exp_ok(0, 1'b0, 12'h004, 32'h0, 32'h5, n + 1 + 3 * i);
    drain();

    // 5: reset during ACCESS aborts silently and restores the pointer
    n = cyc;
    start(0, 1'b0, 12'h000, 32'h0, 1);
    tick();
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    m_req    = '0;
    rem[0]   = 0;
    request(1);
    n = cyc;
    start(0, 1'b0, 12'h004, 32'h0, 1);
    start(1, 1'b0, 12'h000, 32'h0, 1);
    exp_ok(0, 1'b0, 12'h004, 32'h0, 32'h5, n + 1);
    exp_ok(1, 1'b0, 12'h000, 32'h0, 32'h5, n + 4);
    drain();

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
